// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the calculator front-end sequencer: opcodes, FSM states, widths.
package alu_sequencer_pkg;

    localparam int DW_DEF  = 8;
    localparam int RW_DEF  = 16;
    localparam int NUM_OPS = 5;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_EXP = 3'd4;

    // Bit positions inside the one-hot op vector
    localparam int IDX_DIV = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPA  = 3'd1,
        S_OPB  = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/alu_sequencer_op_decode.sv
// Opcode to one-hot ALU strobe decode with a legality flag (codes 5..7 are illegal).
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [2:0]         op_code_i,
    output logic [NUM_OPS-1:0] onehot_o,
    output logic               legal_o
);

    always_comb begin
        onehot_o = '0;
        legal_o  = 1'b1;
        case (op_code_i)
            OP_ADD:  onehot_o = 5'b00001;
            OP_SUB:  onehot_o = 5'b00010;
            OP_MUL:  onehot_o = 5'b00100;
            OP_DIV:  onehot_o = 5'b01000;
            OP_EXP:  onehot_o = 5'b10000;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the 8-bit signed calculator ALU: operand/op capture,
// timed ALU strobing, result capture, chaining and error handling.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int ALU_LAT = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          KEY_VALID,
    input  logic [DW-1:0] KEY_DATA,
    input  logic          OP_VALID,
    input  logic [2:0]    OP_CODE,
    input  logic          EQUALS,
    input  logic          CLEAR,
    output logic [DW-1:0] ALU_A,
    output logic [DW-1:0] ALU_B,
    output logic          ALU_ADD,
    output logic          ALU_SUB,
    output logic          ALU_MUL,
    output logic          ALU_DIV,
    output logic          ALU_EXP,
    input  logic [RW-1:0] ALU_R,
    input  logic          ALU_OVF,
    output logic [RW-1:0] RESULT,
    output logic          RES_VALID,
    output logic          ERR,
    output logic          BUSY
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t               state_q, state_d;
    logic [DW-1:0]        a_q, a_d, b_q, b_d;
    logic [NUM_OPS-1:0]   op_q, op_d;
    logic                 bl_q, bl_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RW-1:0]        result_q, result_d;
    logic                 rv_q, rv_d;

    logic [NUM_OPS-1:0]   dec_onehot;
    logic                 dec_legal;
    logic                 op_top, key_top;
    logic                 res_fits;
    logic [DW-1:0]        chain_a;

    alu_op_decode u_dec (
        .op_code_i (OP_CODE),
        .onehot_o  (dec_onehot),
        .legal_o   (dec_legal)
    );

    // Only the highest-priority entry strobe acts; the rest are dropped
    assign op_top  = OP_VALID & ~EQUALS;
    assign key_top = KEY_VALID & ~OP_VALID & ~EQUALS;

    // Result fits signed DW bits when its upper bits are pure sign extension
    assign res_fits = (&result_q[RW-1:DW-1]) | ~(|result_q[RW-1:DW-1]);
    assign chain_a  = op_q[IDX_DIV] ? ALU_R[RW-1 -: DW] : result_q[DW-1:0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        bl_d     = bl_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rv_d     = 1'b0;
        if (CLEAR) begin
            state_d  = S_IDLE;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            bl_d     = 1'b0;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            case (state_q)
                S_IDLE: if (key_top) begin
                    a_d     = KEY_DATA;
                    state_d = S_OPA;
                end
                S_OPA: begin
                    if (op_top) begin
                        if (dec_legal) begin
                            op_d    = dec_onehot;
                            bl_d    = 1'b0;
                            state_d = S_OPB;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (key_top) begin
                        a_d = KEY_DATA;
                    end
                end
                S_OPB: begin
                    if (EQUALS) begin
                        if (bl_q) begin
                            cnt_d   = CW'(ALU_LAT - 1);
                            state_d = S_EXEC;
                        end
                    end else if (op_top) begin
                        if (dec_legal) op_d = dec_onehot;
                        else           state_d = S_ERR;
                    end else if (key_top) begin
                        b_d  = KEY_DATA;
                        bl_d = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        if (ALU_OVF) begin
                            state_d = S_ERR;
                        end else begin
                            result_d = ALU_R;
                            rv_d     = 1'b1;
                            state_d  = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (op_top) begin
                        if (dec_legal && (op_q[IDX_DIV] || res_fits)) begin
                            a_d     = chain_a;
                            op_d    = dec_onehot;
                            bl_d    = 1'b0;
                            state_d = S_OPB;
                        end else begin
                            state_d = S_ERR;
                        end
                    end else if (key_top) begin
                        a_d     = KEY_DATA;
                        state_d = S_OPA;
                    end
                end
                S_ERR:   ;
                default: state_d = S_IDLE;
            endcase
            if (state_d == S_ERR) result_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            bl_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            bl_q     <= bl_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rv_q     <= rv_d;
        end
    end

    // Strobes derive from the state register so an async reset drops them at once
    assign {ALU_EXP, ALU_DIV, ALU_MUL, ALU_SUB, ALU_ADD} =
        (state_q == S_EXEC) ? op_q : '0;

    assign ALU_A     = a_q;
    assign ALU_B     = b_q;
    assign RESULT    = result_q;
    assign RES_VALID = rv_q;
    assign ERR       = (state_q == S_ERR);
    assign BUSY      = (state_q == S_EXEC);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus random strobes against a reference model.
module tb_alu_sequencer;

    localparam int LAT = 2;
    localparam int M_IDLE = 0, M_OPA = 1, M_OPB = 2, M_EXEC = 3, M_DONE = 4, M_ERR = 5;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        KEY_VALID, OP_VALID, EQUALS, CLEAR;
    logic [7:0]  KEY_DATA;
    logic [2:0]  OP_CODE;
    logic [7:0]  ALU_A, ALU_B;
    logic        ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV, ALU_EXP;
    logic [15:0] ALU_R;
    logic        ALU_OVF;
    logic [15:0] RESULT;
    logic        RES_VALID, ERR, BUSY;
    logic [4:0]  strb;

    int n_chk = 0;
    int n_err = 0;

    alu_sequencer #(.DW(8), .RW(16), .ALU_LAT(LAT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .KEY_VALID(KEY_VALID), .KEY_DATA(KEY_DATA),
        .OP_VALID(OP_VALID), .OP_CODE(OP_CODE),
        .EQUALS(EQUALS), .CLEAR(CLEAR),
        .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_ADD(ALU_ADD), .ALU_SUB(ALU_SUB), .ALU_MUL(ALU_MUL),
        .ALU_DIV(ALU_DIV), .ALU_EXP(ALU_EXP),
        .ALU_R(ALU_R), .ALU_OVF(ALU_OVF),
        .RESULT(RESULT), .RES_VALID(RES_VALID), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    assign strb = {ALU_EXP, ALU_DIV, ALU_MUL, ALU_SUB, ALU_ADD};

    // Arithmetic behaviour of the ALU itself (environment and model share it)
    function automatic void alu_f(input logic [7:0] a, input logic [7:0] b, input int op,
                                  output logic [15:0] r, output logic o);
        int sa, sb, q, m;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        r  = '0;
        o  = 1'b0;
        case (op)
            0: r = 16'(sa + sb);
            1: r = 16'(sa - sb);
            2: r = 16'(sa * sb);
            3: if (sb == 0 || (sa == -128 && sb == -1)) o = 1'b1;
               else begin
                   q = sa / sb;
                   m = sa % sb;
                   r = {q[7:0], m[7:0]};
               end
            4: if (sb < 0) o = 1'b1;
               else begin
                   p = 1;
                   for (int i = 0; i < sb && !o; i++) begin
                       p = p * sa;
                       if (p > 65535 || p < -32768) o = 1'b1;
                   end
                   if (!o) r = p[15:0];
               end
            default: o = 1'b1;
        endcase
    endfunction

    // ALU stand-in: output register updated while a strobe is active, held otherwise
    logic [15:0] alu_tr;
    logic        alu_to;
    int          alu_op;
    always @(posedge CLK) begin
        if (|strb) begin
            alu_op = 0;
            for (int i = 0; i < 5; i++) if (strb[i]) alu_op = i;
            alu_f(ALU_A, ALU_B, alu_op, alu_tr, alu_to);
            ALU_R   <= alu_tr;
            ALU_OVF <= alu_to;
        end
    end

    // Reference model state
    int          m_st, m_op, m_left;
    logic [7:0]  m_a, m_b;
    logic        m_bl, m_rv;
    logic [15:0] m_res, m_last;

    task automatic m_reset();
        m_st = M_IDLE; m_op = 0; m_left = 0; m_a = '0; m_b = '0;
        m_bl = 1'b0; m_rv = 1'b0; m_res = '0;
    endtask

    task automatic m_step(input logic k, input logic [7:0] kd, input logic ov,
                          input logic [2:0] oc, input logic eq, input logic cl);
        logic [15:0] r;
        logic        o;
        int          rs;
        m_rv = 1'b0;
        if (cl) begin
            m_reset();
        end else if (m_st == M_EXEC) begin
            m_left--;
            if (m_left == 0) begin
                alu_f(m_a, m_b, m_op, r, o);
                if (o) begin m_st = M_ERR; m_res = '0; end
                else begin m_res = r; m_last = r; m_rv = 1'b1; m_st = M_DONE; end
            end
        end else if (m_st != M_ERR) begin
            if (eq) begin
                if (m_st == M_OPB && m_bl) begin m_st = M_EXEC; m_left = LAT; end
            end else if (ov) begin
                rs = $signed(m_res);
                if (m_st == M_OPA || m_st == M_OPB) begin
                    if (oc < 5) begin
                        m_op = oc;
                        if (m_st == M_OPA) begin m_bl = 1'b0; m_st = M_OPB; end
                    end else begin
                        m_st = M_ERR; m_res = '0;
                    end
                end else if (m_st == M_DONE) begin
                    if (oc < 5 && (m_op == 3 || (rs >= -128 && rs <= 127))) begin
                        m_a  = (m_op == 3) ? m_last[15:8] : m_res[7:0];
                        m_op = oc; m_bl = 1'b0; m_st = M_OPB;
                    end else begin
                        m_st = M_ERR; m_res = '0;
                    end
                end
            end else if (k) begin
                if (m_st == M_OPB) begin m_b = kd; m_bl = 1'b1; end
                else begin m_a = kd; m_st = M_OPA; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string ph);
        logic [4:0] es;
        es = (m_st == M_EXEC) ? 5'(1 << m_op) : 5'd0;
        chk({ph, ":A"}, ALU_A, m_a);
        chk({ph, ":B"}, ALU_B, m_b);
        chk({ph, ":strb"}, strb, es);
        chk({ph, ":res"}, RESULT, m_res);
        chk({ph, ":rv"}, RES_VALID, m_rv);
        chk({ph, ":err"}, ERR, m_st == M_ERR);
        chk({ph, ":busy"}, BUSY, m_st == M_EXEC);
    endtask

    task automatic cycle(input logic k, input logic [7:0] kd, input logic ov,
                         input logic [2:0] oc, input logic eq, input logic cl);
        @(negedge CLK);
        KEY_VALID = k; KEY_DATA = kd; OP_VALID = ov; OP_CODE = oc; EQUALS = eq; CLEAR = cl;
        @(posedge CLK);
        m_step(k, kd, ov, oc, eq, cl);
        #1;
        check_outputs("cyc");
    endtask

    task automatic idle();              cycle(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b0); endtask
    task automatic key(input int v);    cycle(1'b1, 8'(v), 1'b0, 3'd0, 1'b0, 1'b0); endtask
    task automatic op(input int c);     cycle(1'b0, 8'd0, 1'b1, 3'(c), 1'b0, 1'b0); endtask
    task automatic eql();               cycle(1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 1'b0); endtask
    task automatic clr();               cycle(1'b0, 8'd0, 1'b0, 3'd0, 1'b0, 1'b1); endtask

    initial begin
        RST_N = 1'b0;
        KEY_VALID = 0; KEY_DATA = 0; OP_VALID = 0; OP_CODE = 0; EQUALS = 0; CLEAR = 0;
        ALU_R = '0; ALU_OVF = 1'b0; m_last = '0;
        m_reset();
        #2;
        check_outputs("reset");
        @(negedge CLK); @(negedge CLK);
        RST_N = 1'b1;

        // ADD 5 + -3, latency and strobe
        key(5); op(0); key(-3); eql();
        chk("add_strb", strb, 5'b00001);
        idle();
        chk("add_rv_early", RES_VALID, 1'b0);
        idle();
        chk("add_rv", RES_VALID, 1'b1);
        chk("add_res", RESULT, 16'h0002);
        idle();
        chk("add_rv_pulse", RES_VALID, 1'b0);

        // EXP 2^15 accepted, EXP with negative exponent errors
        clr(); key(2); op(4); key(15); eql(); idle(); idle();
        chk("exp_res", RESULT, 16'h8000);
        clr(); key(2); op(4); key(-1); eql(); idle(); idle();
        chk("exp_err", ERR, 1'b1);
        chk("exp_err_res", RESULT, 16'h0000);
        clr();
        chk("exp_clr", ERR, 1'b0);

        // DIV then chain MUL from the quotient
        key(7); op(3); key(2); eql(); idle(); idle();
        chk("div_res", RESULT, 16'h0301);
        op(2);
        chk("chain_a", ALU_A, 8'd3);
        key(4); eql(); idle(); idle();
        chk("chain_res", RESULT, 16'h000C);

        // Out-of-range chain
        clr(); key(100); op(2); key(100); eql(); idle(); idle();
        chk("mul_res", RESULT, 16'd10000);
        op(0);
        chk("chain_oor", ERR, 1'b1);

        // Illegal op, EQUALS before operand B
        clr(); key(1); op(6);
        chk("illegal_op", ERR, 1'b1);
        clr(); key(1); op(0); eql();
        chk("eq_no_b", BUSY, 1'b0);
        key(2); eql();
        chk("eq_with_b", BUSY, 1'b1);
        idle(); idle();
        chk("eq_res", RESULT, 16'd3);

        // CLEAR during EXEC
        clr(); key(4); op(1); key(1); eql(); clr();
        chk("clr_exec_strb", strb, 5'b0);
        idle();
        chk("clr_exec_rv", RES_VALID, 1'b0);

        // Async reset during EXEC
        key(4); op(1); key(1); eql();
        @(negedge CLK);
        KEY_VALID = 0; OP_VALID = 0; EQUALS = 0; CLEAR = 0;
        RST_N = 1'b0;
        #1;
        chk("arst_strb", strb, 5'b0);
        chk("arst_busy", BUSY, 1'b0);
        m_reset();
        check_outputs("arst");
        @(negedge CLK);
        RST_N = 1'b1;

        // KEY and OP in the same cycle in OPA: op wins, key dropped
        key(9);
        cycle(1'b1, 8'd55, 1'b1, 3'd1, 1'b0, 1'b0);
        chk("key_op_a", ALU_A, 8'd9);
        key(3); eql(); idle(); idle();
        chk("key_op_res", RESULT, 16'd6);

        // Random strobes against the model
        clr();
        for (int n = 0; n < 3000; n++) begin
            logic       k, ov, eq, cl;
            logic [7:0] kd;
            logic [2:0] oc;
            cl = ($urandom_range(0, 39) == 0);
            eq = ($urandom_range(0, 5) == 0);
            ov = ($urandom_range(0, 5) == 0);
            k  = ($urandom_range(0, 3) == 0);
            kd = $urandom_range(0, 1) ? 8'($urandom_range(0, 12) - 4) : 8'($urandom);
            oc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            cycle(k, kd, ov, oc, eq, cl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
